care_scheduler: RTL and testbench
=================================

CARE_SCHEDULER -- requirements
Module: care_scheduler

Interface
REQ-001 The block SHALL have parameter COOK_CYC, default 3, giving the COOK phase length in cycles (legal 1..15).
REQ-002 The block SHALL have parameter BOOK_CYC, default 2, giving the BOOK phase length in cycles (legal 1..15).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port resetb, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port req, input, 2 bits, level service request per child; req[i] is held high until done[i].
REQ-006 The block SHALL have port grant, output, 2 bits, one-hot, registered; grant[i] is high for the whole service of child i.
REQ-007 The block SHALL have port food, output, 1 bit, high during the COOK phase.
REQ-008 The block SHALL have port book, output, 1 bit, high during the BOOK phase.
REQ-009 The block SHALL have port done, output, 2 bits, a one-cycle pulse on done[i] marking the end of service for child i.
REQ-010 The block SHALL have port busy, output, 1 bit, high in any state other than IDLE.

Function
REQ-011 The FSM SHALL have the states IDLE, COOK, BOOK and DONE.
REQ-012 IDLE SHALL go to COOK on the first rising edge where req is nonzero, loading grant with the winning child on that same edge; with req==00 the FSM SHALL stay in IDLE.
REQ-013 COOK SHALL last exactly COOK_CYC cycles, then go to BOOK.
REQ-014 BOOK SHALL last exactly BOOK_CYC cycles, then go to DONE.
REQ-015 DONE SHALL last 1 cycle, then always go to IDLE; IDLE SHALL last at least 1 cycle between services.
REQ-016 Phase timing SHALL use one 4-bit down-counter, loaded with (length-1) on phase entry; the phase SHALL exit when the counter reads 0.
REQ-017 food, book, done and busy SHALL be Moore decodes of the registered state and grant, with no combinational path from req to any output.
REQ-018 done SHALL equal grant while in DONE, and 00 in every other state.
REQ-019 grant SHALL hold its value from COOK entry through DONE, and SHALL be 00 in IDLE.
REQ-020 Arbitration SHALL be round-robin: on req==11 the child not served last wins; on a single request that child wins.
REQ-021 The round-robin pointer SHALL update only on IDLE->COOK.
REQ-022 Deassertion of req[i] mid-service SHALL NOT abort the service; the sequence SHALL complete and done[i] SHALL still pulse.
REQ-023 A request arriving during a service SHALL be considered only at the next IDLE cycle.
REQ-024 At most one grant bit SHALL be set at any time.

Reset
REQ-025 While resetb is low, asynchronously: state=IDLE, counter=0, grant=00, food=0, book=0, done=00, busy=0.
REQ-026 While resetb is low, the round-robin pointer SHALL be reset so that child 0 wins the first req==11.
REQ-027 Reset asserted mid-service SHALL discard that service with no done pulse; the next request SHALL receive a full-length COOK.

Structure
REQ-028 The state encoding and the COOK_CYC/BOOK_CYC defaults SHALL live in the shared package care_pkg.
REQ-029 Arbitration SHALL be a combinational sub-module rr_arb2 (inputs req and last-served pointer, output one-hot winner).
REQ-030 The FSM, counter, pointer and output registers SHALL reside in care_scheduler.

Verification (COOK_CYC=3, BOOK_CYC=2)
REQ-031 Reset check: pulse resetb low with req=11 -> all outputs 0 during reset; after release, the first grant is 01.
REQ-032 Single-request timing: req=01 sampled at edge E0 -> grant=01 for E0..E6; food high after E0/E1/E2; book high after E3/E4; done=01 after E5 only; grant=00 after E6.
REQ-033 Round-robin: req=11 held continuously -> grant sequence 01,10,01,10; each grant lasts 6 cycles with one IDLE cycle between grants.
REQ-034 Early drop: req[1] falls in the second COOK cycle -> BOOK still occurs and done=10 still pulses at the expected cycle.
REQ-035 Reset mid-BOOK: resetb low during BOOK -> book and grant drop immediately with no done pulse; after release, req=01 gives 3 food cycles.
REQ-036 Late request: req[1] rises during service of child 0 while req[0] stays held -> the next grant is 10.

Source files
------------

// File: rtl/care_pkg.sv
// Shared definitions for the care scheduler: FSM state encoding and the
// default phase lengths.
package care_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_COOK = 2'd1,
        ST_BOOK = 2'd2,
        ST_DONE = 2'd3
    } care_state_e;

    localparam int unsigned COOK_CYC_DEF = 32'd3;
    localparam int unsigned BOOK_CYC_DEF = 32'd2;

endpackage : care_pkg

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. Purely combinational: given the request
// vector and the index of the child served last, returns a one-hot winner.
// When both children request, the one not served last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] winner
);

    // Pick the winner from the request pattern and the last-served index
    always_comb begin
        winner = 2'b00;
        case (req)
            2'b01:   winner = 2'b01;
            2'b10:   winner = 2'b10;
            2'b11:   winner = last ? 2'b01 : 2'b10;
            default: winner = 2'b00;
        endcase
    end

endmodule : rr_arb2

// File: rtl/care_scheduler.sv
// Care scheduler: serves one of two children at a time through a fixed
// COOK -> BOOK -> DONE sequence, with round-robin arbitration between them.
// All outputs are registered; they are decoded from the next state so that
// they line up exactly with the registered state they describe.
module care_scheduler
    import care_pkg::*;
#(
    parameter int unsigned COOK_CYC = COOK_CYC_DEF,
    parameter int unsigned BOOK_CYC = BOOK_CYC_DEF
) (
    input  logic       clk,
    input  logic       resetb,
    input  logic [1:0] req,
    output logic [1:0] grant,
    output logic       food,
    output logic       book,
    output logic [1:0] done,
    output logic       busy
);

    localparam logic [3:0] COOK_LOAD = 4'(COOK_CYC - 32'd1);
    localparam logic [3:0] BOOK_LOAD = 4'(BOOK_CYC - 32'd1);

    care_state_e state_r;
    care_state_e state_s;
    logic [3:0]  cnt_r;
    logic [3:0]  cnt_s;
    logic [1:0]  grant_r;
    logic [1:0]  grant_s;
    logic        last_r;   // index of the child served last
    logic        last_s;
    logic [1:0]  win_s;
    logic        food_r;
    logic        book_r;
    logic [1:0]  done_r;
    logic        busy_r;

    rr_arb2 u_arb (
        .req    (req),
        .last   (last_r),
        .winner (win_s)
    );

    // Next-state, phase counter, grant and pointer logic
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        grant_s = grant_r;
        last_s  = last_r;
        case (state_r)
            ST_IDLE: begin
                if (win_s != 2'b00) begin
                    state_s = ST_COOK;
                    cnt_s   = COOK_LOAD;
                    grant_s = win_s;
                    last_s  = win_s[1];
                end else begin
                    state_s = ST_IDLE;
                    cnt_s   = 4'd0;
                    grant_s = 2'b00;
                end
            end
            ST_COOK: begin
                if (cnt_r == 4'd0) begin
                    state_s = ST_BOOK;
                    cnt_s   = BOOK_LOAD;
                end else begin
                    cnt_s   = cnt_r - 4'd1;
                end
            end
            ST_BOOK: begin
                if (cnt_r == 4'd0) begin
                    state_s = ST_DONE;
                    cnt_s   = 4'd0;
                end else begin
                    cnt_s   = cnt_r - 4'd1;
                end
            end
            ST_DONE: begin
                // Always pass through IDLE so late requests get arbitrated fairly
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
                grant_s = 2'b00;
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
                grant_s = 2'b00;
            end
        endcase
    end

    // State, counter, pointer and registered output decodes
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            grant_r <= 2'b00;
            last_r  <= 1'b1;   // child 0 wins the first contested request
            food_r  <= 1'b0;
            book_r  <= 1'b0;
            done_r  <= 2'b00;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            grant_r <= grant_s;
            last_r  <= last_s;
            food_r  <= (state_s == ST_COOK);
            book_r  <= (state_s == ST_BOOK);
            done_r  <= (state_s == ST_DONE) ? grant_s : 2'b00;
            busy_r  <= (state_s != ST_IDLE);
        end
    end

    assign grant = grant_r;
    assign food  = food_r;
    assign book  = book_r;
    assign done  = done_r;
    assign busy  = busy_r;

endmodule : care_scheduler

// File: tb/tb_care_scheduler.sv
// Self-checking bench for care_scheduler. The reference model tracks a
// service as "cycles elapsed since the grant edge" and derives every
// expected output from the phase lengths with plain arithmetic.
module tb_care_scheduler;

    localparam int COOK = 3;
    localparam int BOOKL = 2;
    localparam int TOT = COOK + BOOKL;

    logic       clk;
    logic       resetb;
    logic [1:0] req;
    logic [1:0] grant;
    logic       food;
    logic       book;
    logic [1:0] done;
    logic       busy;

    int total;
    int bad;

    // model: active service, elapsed cycles, served child, last served child
    int m_active;
    int m_t;
    int m_child;
    int m_last;

    care_scheduler #(.COOK_CYC(COOK), .BOOK_CYC(BOOKL)) dut (
        .clk    (clk),
        .resetb (resetb),
        .req    (req),
        .grant  (grant),
        .food   (food),
        .book   (book),
        .done   (done),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0;
        m_t      = 0;
        m_child  = 0;
        m_last   = 1;
    endtask

    // advance the model by one rising edge using the sampled request
    task automatic model_edge(input logic [1:0] r);
        if (m_active != 0) begin
            if (m_t == TOT) m_active = 0;
            else m_t = m_t + 1;
        end else if (r != 2'b00) begin
            if (r == 2'b11) m_child = (m_last == 1) ? 0 : 1;
            else m_child = r[1] ? 1 : 0;
            m_last   = m_child;
            m_active = 1;
            m_t      = 0;
        end
    endtask

    task automatic check_all();
        logic [1:0] eg;
        logic [1:0] ed;
        logic       ef;
        logic       eb;
        eg = (m_active != 0) ? ((m_child != 0) ? 2'b10 : 2'b01) : 2'b00;
        ef = (m_active != 0) && (m_t < COOK);
        eb = (m_active != 0) && (m_t >= COOK) && (m_t < TOT);
        ed = ((m_active != 0) && (m_t == TOT)) ? eg : 2'b00;
        chk("grant", grant, eg);
        chk("food", {1'b0, food}, {1'b0, ef});
        chk("book", {1'b0, book}, {1'b0, eb});
        chk("done", done, ed);
        chk("busy", {1'b0, busy}, {1'b0, m_active != 0});
        chk("grant_onehot", {1'b0, $countones(grant) <= 1}, 2'b01);
    endtask

    // drive req, take one edge, check outputs 1 time unit later
    task automatic step(input logic [1:0] r);
        req = r;
        @(posedge clk);
        model_edge(r);
        #1;
        check_all();
    endtask

    // assert reset away from the clock edge, check, hold, release on negedge
    task automatic do_reset(input int n);
        resetb = 1'b0;
        #1;
        model_reset();
        check_all();
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check_all();
        end
        @(negedge clk);
        resetb = 1'b1;
    endtask

    initial begin
        int fcnt;
        int dcnt;
        total  = 0;
        bad    = 0;
        req    = 2'b11;
        resetb = 1'b1;
        model_reset();
        #2;

        // reset with both children requesting; first grant must be child 0
        do_reset(3);
        step(2'b11);
        chk("first_grant", grant, 2'b01);

        // continuous contention: alternating grants with one idle gap
        for (int i = 0; i < 27; i++) step(2'b11);
        for (int i = 0; i < 8; i++) step(2'b00);

        // single request timing
        step(2'b01);
        chk("single_food", {1'b0, food}, 2'b01);
        for (int i = 0; i < 7; i++) step(2'b00);

        // early drop of req[1] in the second COOK cycle
        step(2'b10);
        step(2'b10);
        for (int i = 0; i < 7; i++) step(2'b00);

        // reset during BOOK
        step(2'b01);
        for (int i = 0; i < 3; i++) step(2'b01);
        chk("in_book", {1'b0, book}, 2'b01);
        #2;
        do_reset(1);
        fcnt = 0;
        dcnt = 0;
        step(2'b01);
        if (food) fcnt++;
        for (int i = 0; i < 8; i++) begin
            step(2'b00);
            if (food) fcnt++;
            if (done != 2'b00) dcnt++;
        end
        chk("food_cycles_after_reset", 2'(fcnt), 2'd3);
        chk("done_pulses_after_reset", 2'(dcnt), 2'd1);

        // late request from child 1 while child 0 still holds req
        step(2'b01);
        step(2'b01);
        for (int i = 0; i < 5; i++) step(2'b11);
        step(2'b11);
        step(2'b11);
        chk("late_req_grant", grant, 2'b10);
        for (int i = 0; i < 8; i++) step(2'b00);

        // randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 63) == 0) begin
                #2;
                do_reset($urandom_range(0, 2));
            end
            step(2'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_care_scheduler
